// File: rtl/booth_mul_seq_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM encoding,
// Booth recoding pairs and the default operand width.
package booth_mul_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // {Q[0], q_m1} pairs that require an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mul_seq_add_sub.sv
// Add/subtract unit built from chained 4-bit carry-lookahead slices.
// Subtract is a + ~b + 1. The top slice is partial: bits past W would only
// repeat the sign, so they are not built. The carry out of the MSB is not
// produced, so the generate term of the top bit is never needed.
module booth_add_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  localparam int NS = (W + 3) / 4;

  logic [W-1:0]  bx;
  logic [W-1:0]  p;
  logic [W-2:0]  g;
  logic [W-1:0]  c;
  logic [NS-1:0] cs;

  assign bx    = b ^ {W{sub}};
  assign p     = a ^ bx;
  assign g     = a[W-2:0] & bx[W-2:0];
  assign cs[0] = sub;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    localparam int BI = 4 * s;

    // in-slice lookahead carries, each bit derived straight from the slice carry-in
    for (genvar k = 0; k < 4; k++) begin : g_bit
      if (BI + k < W) begin : g_live
        if (k == 0) begin : g_c0
          assign c[BI] = cs[s];
        end else if (k == 1) begin : g_c1
          assign c[BI+1] = g[BI] | (p[BI] & cs[s]);
        end else if (k == 2) begin : g_c2
          assign c[BI+2] = g[BI+1] | (p[BI+1] & g[BI]) | (p[BI+1] & p[BI] & cs[s]);
        end else begin : g_c3
          assign c[BI+3] = g[BI+2] | (p[BI+2] & g[BI+1]) | (p[BI+2] & p[BI+1] & g[BI])
                         | (p[BI+2] & p[BI+1] & p[BI] & cs[s]);
        end
      end
    end

    // group carry into the next slice
    if (s < NS - 1) begin : g_cout
      assign cs[s+1] = g[BI+3] | (p[BI+3] & g[BI+2]) | (p[BI+3] & p[BI+2] & g[BI+1])
                     | (p[BI+3] & p[BI+2] & p[BI+1] & g[BI])
                     | (p[BI+3] & p[BI+2] & p[BI+1] & p[BI] & cs[s]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, one recoding step per clock.
// A and M carry one extra sign bit so that subtracting the most negative
// multiplicand cannot overflow.
//
//   state | meaning
//   IDLE  | waiting for start, HI/LO hold the last product
//   RUN   | one Booth add/sub + arithmetic shift per cycle, WIDTH cycles
//   DONE  | single cycle, HI/LO just written; start here re-enters RUN
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [1:0]       booth_bits;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_step;

  assign booth_bits = {q_q[0], qm1_q};

  booth_add_sub #(.W(WIDTH + 1)) u_add_sub (
    .a   (a_q),
    .b   (m_q),
    .sub (booth_bits == BOOTH_SUB),
    .sum (sum)
  );

  assign a_step = ((booth_bits == BOOTH_ADD) || (booth_bits == BOOTH_SUB)) ? sum : a_q;

  // next-state: operand load on accepted start, Booth step + shift while running
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          count_d = COUNT_INIT;
          a_d     = '0;
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          q_d     = multiplier;
          qm1_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = {a_step[WIDTH], a_step[WIDTH:1]};
        q_d     = {a_step[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q - COUNT_ONE;
        if (count_q == COUNT_ONE) begin
          state_d = ST_DONE;
          hi_d    = a_d[WIDTH-1:0];
          lo_d    = q_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq at WIDTH=32.
module tb_booth_mul_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (hi),
    .product_lo   (lo)
  );

  // Pulse start for one edge, then step negedge by negedge until done.
  // done_k is the number of negedges after the start edge (0 = timed out).
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                       output int busy_cnt, output int done_k, output int overlap);
    busy_cnt = 0;
    done_k   = 0;
    overlap  = 0;
    @(negedge clock);
    start = 1'b1; mcand = m; mplier = q;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (busy && done) overlap++;
      if (done) begin done_k = k; break; end
      if (busy) busy_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int bc, dk, ov;
    do_op(32'd6, 32'd7, bc, dk, ov);
    total++; if (dk != 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", dk); end
    total++; if (bc != 32) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
    total++; if (ov != 0) begin bad++; $display("FAIL basic_busy_done_overlap got=%0d exp=0", ov); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL basic_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0000002A) begin bad++; $display("FAIL basic_lo got=%h exp=0000002a", lo); end
    @(negedge clock);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_back_idle got=%b exp=0", busy); end
    total++; if (lo !== 32'h0000002A) begin bad++; $display("FAIL basic_lo_hold got=%h exp=0000002a", lo); end
  endtask

  // Table columns: M, Q, expected HI, expected LO
  task automatic test_vectors();
    logic [W-1:0] tv [8][4];
    int bc, dk, ov;
    tv[0] = '{32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    tv[1] = '{32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    tv[2] = '{32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tv[3] = '{32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tv[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    tv[5] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tv[6] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    for (int i = 0; i < 8; i++) begin
      do_op(tv[i][0], tv[i][1], bc, dk, ov);
      total++; if (dk != 33) begin bad++; $display("FAIL vec%0d_latency got=%0d exp=33", i, dk); end
      total++; if (hi !== tv[i][2]) begin bad++; $display("FAIL vec%0d_hi got=%h exp=%h", i, hi, tv[i][2]); end
      total++; if (lo !== tv[i][3]) begin bad++; $display("FAIL vec%0d_lo got=%h exp=%h", i, lo, tv[i][3]); end
    end
  endtask

  // Last vector left HI/LO = 3FFFFFFF/00000001; they must hold through this run.
  task automatic test_ignore_start();
    int dk = 0;
    @(negedge clock);
    start = 1'b1; mcand = 32'd6; mplier = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin dk = k; break; end
      if (k == 10) begin
        total++; if (hi !== 32'h3FFFFFFF) begin bad++; $display("FAIL ign_hi_hold got=%h exp=3fffffff", hi); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL ign_lo_hold got=%h exp=00000001", lo); end
        start = 1'b1; mcand = 32'd9; mplier = 32'd9;
      end
      if (k == 11) start = 1'b0;
      @(negedge clock);
    end
    total++; if (dk != 33) begin bad++; $display("FAIL ign_latency got=%0d exp=33", dk); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL ign_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0000002A) begin bad++; $display("FAIL ign_lo got=%h exp=0000002a", lo); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int bc, dk, ov;
    int done_seen = 0;
    @(negedge clock);
    start = 1'b1; mcand = 32'd6; mplier = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < 15; k++) @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_running got=%b exp=1", busy); end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h exp=00000000", lo); end
    for (int k = 0; k < 40; k++) begin
      if (done || busy) done_seen++;
      @(negedge clock);
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
    do_op(32'd2, 32'd3, bc, dk, ov);
    total++; if (dk != 33) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d exp=33", dk); end
    total++; if (lo !== 32'h6) begin bad++; $display("FAIL rstmid_fresh_lo got=%h exp=00000006", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_fresh_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_back_to_back();
    int dk1 = 0;
    int dk2 = 0;
    @(negedge clock);
    start = 1'b1; mcand = 32'd6; mplier = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (done) begin dk1 = k; break; end
      @(negedge clock);
    end
    total++; if (dk1 != 33) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=33", dk1); end
    total++; if (lo !== 32'h0000002A) begin bad++; $display("FAIL b2b_first_lo got=%h exp=0000002a", lo); end
    start = 1'b1; mcand = 32'd2; mplier = 32'hFFFFFFFC;
    @(negedge clock);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_idle got=%b exp=1", busy); end
    for (int k = 1; k <= 100; k++) begin
      if (done) begin dk2 = k; break; end
      @(negedge clock);
    end
    total++; if (dk2 != 33) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=33", dk2); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFF8) begin bad++; $display("FAIL b2b_lo got=%h exp=fffffff8", lo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
